m_cp0: RTL and testbench



---
 rtl/m_cp0.sv | 109 ++++++++++
 tb/tb_m_cp0.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/m_cp0.sv
// CP0 for the M stage: SR/Cause/EPC (PRId read-back under CP0_PRID_EN), interrupt/exception arbitration, Req flush.
// Latency: Req, M_cp0_rdata and epc_out are combinational; register updates appear the cycle after the edge.
// Backpressure: none; Req is the pipeline-wide flush that other stages gate their updates on.
module m_cp0 #(
    parameter logic [31:0] PRID_VALUE = 32'h2023_1121
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        M_cp0_we,
    input  logic [4:0]  M_cp0_addr,
    input  logic [31:0] M_cp0_wdata,
    output logic [31:0] M_cp0_rdata,
    input  logic [31:0] M_pc,
    input  logic        M_bd,
    input  logic [4:0]  M_exc_code,
    input  logic        M_eret,
    input  logic [5:0]  hw_int,
    output logic        Req,
    output logic [31:0] epc_out
);

`ifdef CP0_PRID_EN
    localparam logic PRID_EN = 1'b1;
`else
    localparam logic PRID_EN = 1'b0;
`endif

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [31:0] w_epc_next;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic        w_epc_wr;

    assign w_int_req  = (|(hw_int & r_im)) & r_ie & ~r_exl;
    assign w_exc_req  = (M_exc_code != 5'd0) & ~r_exl;
    assign w_req      = w_int_req | w_exc_req;
    // A delay-slot victim restarts at its branch so the branch re-executes.
    assign w_epc_next = (M_bd ? (M_pc - 32'd4) : M_pc) & 32'hFFFF_FFFC;
    assign w_epc_wr   = M_cp0_we && (M_cp0_addr == 5'd14);

    assign w_sr    = {16'd0, r_im, 8'd0, r_exl, r_ie};
    assign w_cause = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'd0};

    assign Req = ~rst & w_req;

    always_comb begin
        epc_out = 32'd0;
        if (!rst) begin
            epc_out = w_epc_wr ? (M_cp0_wdata & 32'hFFFF_FFFC) : r_epc;
        end
    end

    always_comb begin
        M_cp0_rdata = 32'd0;
        if (!rst) begin
            case (M_cp0_addr)
                5'd12:   M_cp0_rdata = w_sr;
                5'd13:   M_cp0_rdata = w_cause;
                5'd14:   M_cp0_rdata = r_epc;
                5'd15:   M_cp0_rdata = PRID_EN ? PRID_VALUE : 32'd0;
                default: M_cp0_rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_im       <= 6'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= 6'd0;
            r_exc_code <= 5'd0;
            r_epc      <= 32'd0;
        end else begin
            r_ip <= hw_int;
            if (w_req) begin
                // Taking the event squashes any mtc0/eret sitting in M.
                r_exl      <= 1'b1;
                r_exc_code <= w_int_req ? 5'd0 : M_exc_code;
                r_bd       <= M_bd;
                r_epc      <= w_epc_next;
            end else begin
                if (M_cp0_we && (M_cp0_addr == 5'd12)) begin
                    r_im  <= M_cp0_wdata[15:10];
                    r_exl <= M_cp0_wdata[1];
                    r_ie  <= M_cp0_wdata[0];
                end
                if (w_epc_wr) begin
                    r_epc <= M_cp0_wdata & 32'hFFFF_FFFC;
                end
                if (M_eret) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_m_cp0.sv
// Directed bench for m_cp0: hand-computed vectors checked with immediate assertions.
module tb_m_cp0;

    logic        clk = 1'b0;
    logic        rst;
    logic        M_cp0_we;
    logic [4:0]  M_cp0_addr;
    logic [31:0] M_cp0_wdata;
    logic [31:0] M_cp0_rdata;
    logic [31:0] M_pc;
    logic        M_bd;
    logic [4:0]  M_exc_code;
    logic        M_eret;
    logic [5:0]  hw_int;
    logic        Req;
    logic [31:0] epc_out;

    int n_vec = 0;
    int n_err = 0;

    m_cp0 dut (
        .clk(clk), .rst(rst),
        .M_cp0_we(M_cp0_we), .M_cp0_addr(M_cp0_addr), .M_cp0_wdata(M_cp0_wdata),
        .M_cp0_rdata(M_cp0_rdata), .M_pc(M_pc), .M_bd(M_bd),
        .M_exc_code(M_exc_code), .M_eret(M_eret), .hw_int(hw_int),
        .Req(Req), .epc_out(epc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        M_cp0_addr = a;
        #1;
        chk(tag, M_cp0_rdata, exp);
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        M_cp0_we = 1'b1; M_cp0_addr = a; M_cp0_wdata = d;
        tick();
        M_cp0_we = 1'b0;
    endtask

    initial begin
        logic [31:0] prid_exp;
`ifdef CP0_PRID_EN
        prid_exp = 32'h2023_1121;
`else
        prid_exp = 32'h0;
`endif
        // Reset: outputs forced to zero even with live requests and a bypass write.
        rst = 1'b1; M_cp0_we = 1'b1; M_cp0_addr = 5'd14; M_cp0_wdata = 32'hFFFF_FFFF;
        M_pc = 32'h0; M_bd = 1'b0; M_exc_code = 5'd4; M_eret = 1'b0; hw_int = 6'd1;
        #1;
        chk("rst_epc_out", epc_out, 32'h0);
        chk("rst_req", {31'd0, Req}, 32'h0);
        tick();
        tick();
        M_cp0_we = 1'b0; M_exc_code = 5'd0; hw_int = 6'd0;
        rd(5'd12, "rst_rdata_hold", 32'h0);
        rst = 1'b0;
        rd(5'd12, "reset_sr", 32'h0);
        rd(5'd13, "reset_cause", 32'h0);
        rd(5'd14, "reset_epc", 32'h0);

        // Interrupt: IM[0]=1, IE=1.
        mtc0(5'd12, 32'h0000_0401);
        rd(5'd12, "sr_write", 32'h0000_0401);
        hw_int = 6'd1; M_pc = 32'h3010; M_bd = 1'b0;
        #1;
        chk("int_req", {31'd0, Req}, 32'h1);
        tick();
        chk("int_req_held_off", {31'd0, Req}, 32'h0);
        rd(5'd14, "int_epc", 32'h3010);
        chk("int_epc_out", epc_out, 32'h3010);
        rd(5'd13, "int_cause", 32'h0000_0400);
        rd(5'd12, "int_sr_exl", 32'h0000_0403);

        // eret clears EXL; still-pending interrupt fires next cycle.
        M_eret = 1'b1;
        #1;
        chk("eret_cycle_req", {31'd0, Req}, 32'h0);
        tick();
        M_eret = 1'b0;
        #1;
        chk("post_eret_req", {31'd0, Req}, 32'h1);
        rd(5'd12, "post_eret_sr", 32'h0000_0401);
        hw_int = 6'd0;
        #1;
        chk("int_drop_req", {31'd0, Req}, 32'h0);

        // Exception in a delay slot.
        mtc0(5'd12, 32'h0000_0001);
        M_exc_code = 5'd10; M_pc = 32'h3024; M_bd = 1'b1;
        #1;
        chk("exc_req", {31'd0, Req}, 32'h1);
        tick();
        chk("exc_held_off", {31'd0, Req}, 32'h0);
        M_exc_code = 5'd0; M_bd = 1'b0;
        rd(5'd14, "exc_epc_bd", 32'h3020);
        rd(5'd13, "exc_cause", 32'h8000_0028);
        M_eret = 1'b1;
        tick();
        M_eret = 1'b0;
        rd(5'd12, "exc_eret_sr", 32'h0000_0001);

        // Interrupt + exception + mtc0 EPC together.
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'd1; M_exc_code = 5'd4; M_pc = 32'h3100;
        M_cp0_we = 1'b1; M_cp0_addr = 5'd14; M_cp0_wdata = 32'h5555;
        #1;
        chk("both_req", {31'd0, Req}, 32'h1);
        chk("both_epc_bypass", epc_out, 32'h5554);
        tick();
        M_cp0_we = 1'b0; M_exc_code = 5'd0; hw_int = 6'd0;
        rd(5'd14, "both_epc_discard", 32'h3100);
        rd(5'd13, "both_cause_int", 32'h0000_0400);

        // mtc0 EPC with eret: bypass immediately, register next cycle.
        M_cp0_we = 1'b1; M_cp0_addr = 5'd14; M_cp0_wdata = 32'h3007; M_eret = 1'b1;
        #1;
        chk("bypass_epc_out", epc_out, 32'h3004);
        M_cp0_addr = 5'd14;
        tick();
        M_cp0_we = 1'b0; M_eret = 1'b0;
        rd(5'd14, "bypass_epc_reg", 32'h3004);
        rd(5'd12, "bypass_sr", 32'h0000_0401);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, "cause_write_ignored", 32'h0);
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, "sr_mask", 32'h0000_FC03);
        M_eret = 1'b1;
        mtc0(5'd12, 32'h0000_0403);
        M_eret = 1'b0;
        rd(5'd12, "eret_wins_exl", 32'h0000_0401);
        rd(5'd5, "unimpl_reg", 32'h0);
        mtc0(5'd15, 32'h1234_5678);
        rd(5'd15, "prid", prid_exp);

        // Reset with EXL set and events pending.
        mtc0(5'd12, 32'h0000_0003);
        rst = 1'b1; hw_int = 6'd1; M_exc_code = 5'd4;
        tick();
        rst = 1'b0; hw_int = 6'd0; M_exc_code = 5'd0;
        rd(5'd12, "rst2_sr", 32'h0);
        rd(5'd13, "rst2_cause", 32'h0);
        rd(5'd14, "rst2_epc", 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
